// File: rtl/io_ccff_loader_pkg.sv
// io_ccff_loader shared types: FSM state encoding and counter sizing.
// Optional readback is enabled by defining IO_CCFF_READBACK_EN.
package io_ccff_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FRST,
        ST_SHIFT,
        ST_SETTLE,
        ST_RELEASE
    } state_e;

    // Width of a counter that must hold 0..n without wrapping
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/io_ccff_serializer.sv
// Word buffer for the configuration chain: accepts stream words and
// presents them LSB-first on ccff_head, one bit per enabled cycle.
module io_ccff_serializer
    import io_ccff_loader_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              active_i,
    input  logic              more_i,
    input  logic              cfg_valid_i,
    input  logic [WORD_W-1:0] cfg_data_i,
    output logic              cfg_ready_o,
    output logic              bit_valid_o,
    output logic              head_o
);

    localparam int RMW = cnt_w(WORD_W);

    logic [WORD_W-1:0] buf_q;
    logic [RMW-1:0]    rem_q;
    logic              head_q;
    logic              empty;
    logic              accept;

    assign empty       = (rem_q == '0);
    assign bit_valid_o = active_i && !empty;
    // Refill early on the last bit so consecutive words shift without a gap
    assign cfg_ready_o = active_i &&
                         (empty || ((rem_q == RMW'(1)) && more_i));
    assign accept      = cfg_valid_i && cfg_ready_o;
    assign head_o      = bit_valid_o ? buf_q[0] : head_q;

    // Buffer load / shift; leftover bits are dropped once shifting ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q  <= '0;
            rem_q  <= '0;
            head_q <= 1'b0;
        end else begin
            if (bit_valid_o) begin
                head_q <= buf_q[0];
            end
            if (!active_i) begin
                rem_q <= '0;
            end else if (accept) begin
                buf_q <= cfg_data_i;
                rem_q <= RMW'(WORD_W);
            end else if (bit_valid_o) begin
                buf_q <= buf_q >> 1;
                rem_q <= rem_q - RMW'(1);
            end
        end
    end

endmodule

// File: rtl/io_ccff_loader.sv
// I/O tile configuration-chain loader: FSM, bit counter, pad sequencing.
// Define IO_CCFF_READBACK_EN to add ccff_tail capture (rd_valid/rd_data).
module io_ccff_loader
    import io_ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN  = 64,
    parameter int WORD_W     = 8,
    parameter int RST_CYCLES = 4
) (
    input  logic              prog_clk,
    input  logic              pReset_N,
    input  logic              start,
    input  logic              cfg_valid,
    input  logic [WORD_W-1:0] cfg_data,
    output logic              cfg_ready,
    output logic              busy,
    output logic              configured,
    output logic              fabric_pReset,
    output logic              config_enable,
    output logic              ccff_head,
    input  logic              ccff_tail,
`ifdef IO_CCFF_READBACK_EN
    output logic              rd_valid,
    output logic [WORD_W-1:0] rd_data,
`endif
    output logic              IO_ISOL_N
);

    localparam int CW = cnt_w(CHAIN_LEN);
    localparam int RW = cnt_w(RST_CYCLES);

    state_e         state_q;
    logic [CW-1:0]  bit_cnt_q;
    logic [RW-1:0]  rst_cnt_q;
    logic           configured_q;
    logic           isol_n_q;
    logic           fpreset_q;
    logic           bit_en;
    logic           more;
    logic           last_bit;

    assign busy          = (state_q != ST_IDLE);
    assign configured    = configured_q;
    assign IO_ISOL_N     = isol_n_q;
    assign fabric_pReset = fpreset_q;
    assign config_enable = bit_en;
    assign more          = (bit_cnt_q != CW'(CHAIN_LEN - 1));
    assign last_bit      = bit_en && !more;

    io_ccff_serializer #(
        .WORD_W (WORD_W)
    ) u_ser (
        .clk         (prog_clk),
        .rst_n       (pReset_N),
        .active_i    (state_q == ST_SHIFT),
        .more_i      (more),
        .cfg_valid_i (cfg_valid),
        .cfg_data_i  (cfg_data),
        .cfg_ready_o (cfg_ready),
        .bit_valid_o (bit_en),
        .head_o      (ccff_head)
    );

    // Load sequencer; pads stay isolated until the chain is complete
    always_ff @(posedge prog_clk or negedge pReset_N) begin
        if (!pReset_N) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            rst_cnt_q    <= '0;
            configured_q <= 1'b0;
            isol_n_q     <= 1'b0;
            fpreset_q    <= 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q      <= ST_FRST;
                        rst_cnt_q    <= '0;
                        configured_q <= 1'b0;
                        isol_n_q     <= 1'b0;
                        fpreset_q    <= 1'b1;
                    end
                end
                ST_FRST: begin
                    if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
                        state_q   <= ST_SHIFT;
                        bit_cnt_q <= '0;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + RW'(1);
                    end
                end
                ST_SHIFT: begin
                    if (bit_en) begin
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                        if (!more) begin
                            state_q   <= ST_SETTLE;
                            fpreset_q <= 1'b0;
                        end
                    end
                end
                ST_SETTLE: begin
                    state_q      <= ST_RELEASE;
                    isol_n_q     <= 1'b1;
                    configured_q <= 1'b1;
                end
                ST_RELEASE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef IO_CCFF_READBACK_EN
    localparam int IW = cnt_w(WORD_W - 1);

    logic [WORD_W-1:0] acc_q;
    logic [WORD_W-1:0] acc_nx;
    logic [IW-1:0]     idx_q;

    // Merge the bit arriving on ccff_tail this cycle into the word
    always_comb begin
        acc_nx         = acc_q;
        acc_nx[idx_q]  = ccff_tail;
    end

    // Collect old chain contents; flush full or final partial words
    always_ff @(posedge prog_clk or negedge pReset_N) begin
        if (!pReset_N) begin
            acc_q    <= '0;
            idx_q    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= 1'b0;
            if (state_q == ST_IDLE && start) begin
                acc_q <= '0;
                idx_q <= '0;
            end else if (bit_en) begin
                if (idx_q == IW'(WORD_W - 1) || last_bit) begin
                    rd_valid <= 1'b1;
                    rd_data  <= acc_nx;
                    acc_q    <= '0;
                    idx_q    <= '0;
                end else begin
                    acc_q <= acc_nx;
                    idx_q <= idx_q + IW'(1);
                end
            end
        end
    end
`else
    logic unused_tail;
    logic unused_last;
    assign unused_tail = ccff_tail;
    assign unused_last = last_bit;
`endif

endmodule
